// File: rtl/fifo_umbral.sv
// Per-virtual-channel input FIFO with occupancy flags compared against the
// live low/high thresholds driven by the flow-control FSM.
module fifo_umbral #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_enable,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_enable,
  input  logic [UMBRALES_L_H-1:0] umbral_L,
  input  logic [UMBRALES_L_H-1:0] umbral_H,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    fifo_error,
  output logic [ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    err_now;
  logic [UMBRALES_L_H-1:0] count_ext;

  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    count_ext    = UMBRALES_L_H'(count);
    almost_empty = (count_ext <= umbral_L);
    almost_full  = (count_ext >= umbral_H);
    // A pop on a full FIFO frees the slot the concurrent push lands in.
    wr_acc       = wr_enable && (!full || rd_enable);
    rd_acc       = rd_enable && !empty;
    err_now      = (wr_enable && full && !rd_enable) || (rd_enable && empty);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        data_out  <= mem[rd_ptr];
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_now) fifo_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed plus randomized bench for fifo_umbral, checked against a queue model.
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_enable = 1'b0;
  logic [5:0] data_in = '0;
  logic       rd_enable = 1'b0;
  logic [7:0] umbral_L = 8'd1;
  logic [7:0] umbral_H = 8'd6;
  logic [5:0] data_out;
  logic       valid_out;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       fifo_error;
  logic [3:0] count;

  int tests = 0;
  int failed = 0;

  logic [5:0] q[$];
  logic [5:0] m_data = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;

  fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .UMBRALES_L_H(8)) dut (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .data_in(data_in),
    .rd_enable(rd_enable), .umbral_L(umbral_L), .umbral_H(umbral_H),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_error(fifo_error), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == 8));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= int'(umbral_L)));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= int'(umbral_H)));
    chk({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".error"}, 32'(fifo_error), 32'(m_err));
    if (m_valid) chk({tag, ".data"}, 32'(data_out), 32'(m_data));
  endtask

  task automatic step(input string tag, input logic wr, input logic [5:0] d, input logic rd);
    int n;
    bit rd_acc, wr_acc;
    @(negedge clk);
    wr_enable = wr;
    data_in   = d;
    rd_enable = rd;
    @(posedge clk);
    n = q.size();
    rd_acc = rd && (n != 0);
    wr_acc = wr && ((n != 8) || rd);
    if ((wr && n == 8 && !rd) || (rd && n == 0)) m_err = 1'b1;
    if (rd_acc) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr_acc) q.push_back(d);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  initial begin
    // Reset held for two edges with a push request pending.
    wr_enable = 1'b1;
    data_in   = 6'h15;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.data0", 32'(data_out), 32'h0);
    @(negedge clk);
    wr_enable = 1'b0;
    reset     = 1'b1;

    // Fill 1..8, then an overflowing ninth push.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 6'(i), 1'b0);
    step("overflow", 1'b1, 6'h3C, 1'b0);

    // Drain in order, then one read on empty.
    for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1);
    chk("drain.last", 32'(data_out), 32'h08);
    step("underflow", 1'b0, '0, 1'b1);

    // Simultaneous push/pop on empty: only the push is accepted.
    step("empty_rw", 1'b1, 6'h11, 1'b1);
    step("empty_rw_pop", 1'b0, '0, 1'b1);

    // Advance pointers by 5, then overlap pushes and pops across the wrap.
    for (int i = 0; i < 5; i++) step("adv_push", 1'b1, 6'(8'h20 + i), 1'b0);
    for (int i = 0; i < 5; i++) step("adv_pop", 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step("wrap_rw", 1'b1, 6'(8'h2A + i), 1'b1);
    while (q.size() != 0) step("wrap_tail", 1'b0, '0, 1'b1);

    // Full with simultaneous read/write.
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 6'(8'h30 + i), 1'b0);
    step("full_rw", 1'b1, 6'h3F, 1'b1);
    chk("full_rw.oldest", 32'(data_out), 32'h30);
    for (int i = 0; i < 8; i++) step("full_drain", 1'b0, '0, 1'b1);
    chk("full_drain.last", 32'(data_out), 32'h3F);

    // Asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 6'(i + 5), 1'b0);
    @(negedge clk);
    wr_enable = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst");
    @(negedge clk);
    reset = 1'b1;

    // Live threshold change without a clock edge.
    for (int i = 0; i < 3; i++) step("post_rst", 1'b1, 6'(i + 9), 1'b0);
    @(negedge clk);
    wr_enable = 1'b0;
    #1;
    chk("pre_thr.aempty", 32'(almost_empty), 32'h0);
    umbral_L = 8'd3;
    #1;
    chk_all("live_thr");
    chk("live_thr.aempty", 32'(almost_empty), 32'h1);

    // Randomized traffic with changing thresholds, including edge values.
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = (i / 50) % 2 ? 30 : 70;
      pr = 100 - pw;
      if ($urandom_range(0, 15) == 0) begin
        umbral_L = 8'($urandom_range(0, 10));
        umbral_H = 8'($urandom_range(0, 10));
        #1;
        chk_all("rand_thr");
      end
      step("rand", 1'($urandom_range(0, 99) < pw), 6'($urandom),
           1'($urandom_range(0, 99) < pr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Per-virtual-channel input FIFO that sits directly upstream of the flow-control FSM.
- Buffers data words and produces the empty flag the FSM consumes on its empty_fifo_N inputs.
- Also produces almost_empty / almost_full flags by comparing its occupancy against the low/high thresholds the FSM drives out (umbral_L_out / umbral_H_out).
- Eight instances, one per empty_fifo_0..7, are planned in the switch.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8 entries.
- UMBRALES_L_H, 8, threshold width; matches the FSM threshold outputs.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- wr_enable  input  1  push request.
- data_in  input  DATA_WIDTH  word to push.
- rd_enable  input  1  pop request.
- umbral_L  input  UMBRALES_L_H  low threshold, connected to FSM umbral_L_out.
- umbral_H  input  UMBRALES_L_H  high threshold, connected to FSM umbral_H_out.
- data_out  output  DATA_WIDTH  registered popped word.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- empty  output  1  occupancy == 0; feeds FSM empty_fifo_N.
- full  output  1  occupancy == depth.
- almost_empty  output  1  occupancy <= umbral_L.
- almost_full  output  1  occupancy >= umbral_H.
- fifo_error  output  1  sticky: overflow or underflow attempted.
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth.

Behaviour:
- Reset (reset==0, asynchronous, no clock needed):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, valid_out = 0, fifo_error = 0.
  - Memory contents are not cleared.
- Reset outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (umbral_H == 0).
- Reset released mid-traffic: first active edge is the one after reset rises. All in-flight words are discarded and count restarts at 0.
- Write accept: wr_enable && (!full || rd_enable).
  - Store mem[wr_ptr] = data_in; wr_ptr increments.
  - Pointers wrap modulo depth via natural ADDR_WIDTH overflow.
- Read accept: rd_enable && !empty.
  - data_out <= mem[rd_ptr]; valid_out <= 1; rd_ptr increments.
  - Read latency is 1 cycle: the word is visible the edge after the accepting edge.
- When no read is accepted: valid_out <= 0 and data_out holds its last value.
- count update: next = count + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Full with wr_enable && rd_enable: both accepted. The pop reads the oldest word, the write lands in the freed slot, and count stays at depth.
- Empty with wr_enable && rd_enable:
  - Write is accepted; read is rejected (no fall-through bypass).
  - count becomes 1; valid_out = 0.
  - fifo_error is set, since the read was attempted on empty.
- Overflow (wr_enable && full && !rd_enable): word dropped, pointers and count unchanged, fifo_error <= 1.
- Underflow (rd_enable && empty): no pointer change, valid_out <= 0, fifo_error <= 1.
- fifo_error is sticky; only reset clears it.
- Flags are combinational decodes of the registered count and the live threshold inputs:
  - empty = (count == 0), full = (count == depth).
  - almost_empty = ({zero-extended count} <= umbral_L).
  - almost_full = ({zero-extended count} >= umbral_H).
  - Comparisons are unsigned at UMBRALES_L_H bits.
  - A threshold change takes effect on the flags in the same cycle, with no clock needed.
- Threshold edge cases:
  - umbral_H == 0 forces almost_full = 1.
  - umbral_H > depth forces almost_full = 0.
  - umbral_L >= depth forces almost_empty = 1.
  - Both flags may be 1 at once; no exclusivity is enforced.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_enable=1 and umbral_L=1, umbral_H=6 -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, valid_out=0, fifo_error=0.
- Fill: umbral_L=1, umbral_H=6; push 0x01..0x08 on consecutive edges.
  - almost_empty clears at count=2; almost_full sets at count=6.
  - full=1 at count=8 and empty=0 from count=1.
  - 9th push -> dropped, fifo_error=1, count stays 8.
- Drain order: after fill, rd_enable for 8 cycles -> data_out = 0x01..0x08, each valid_out=1 one cycle after its request.
  - empty=1 after the 8th pop; one extra read -> valid_out=0, fifo_error stays 1.
- Wrap and simultaneous: push 5 and pop 5 (pointers at 5), then push 0x2A..0x2E while popping every cycle.
  - Words exit in order across the wrap 7->0; count stays constant during overlap.
- Full plus simultaneous read/write: at count=8, wr_enable=rd_enable=1 with data_in=0x3F -> count=8, oldest word out, fifo_error unchanged.
  - Draining then returns 0x3F last.
- Async reset mid-operation and live thresholds: at count=4, drop reset between edges -> count=0 and flags at reset values immediately.
  - Then at count=3, change umbral_L 1->3 -> almost_empty=1 in the same cycle.
